// File: rtl/sfp_ctrl.sv
// sfp_ctrl -- sequencer for one core's softmax-style normalisation row unit.
//
// Runs a job of num_rows rows in two passes over the row unit:
//   ACC    : each consumed row is abs-summed into the own sum FIFO (acc)
//   SETTLE : waits SETTLE cycles so the last sum lands in the FIFO
//   SYNC   : raises peer_ready_out and waits for the peer core's level
//   DIV    : each consumed row is divided by own + peer sum (div, fifo_ext_rd)
//   DRAIN  : last out_valid; done pulses, back to IDLE
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset (release synchronised)
//   start          in   one-cycle job request, sampled only in IDLE
//   num_rows       in   rows in the job, captured on an accepted start
//   in_valid       in   upstream row data valid
//   in_rd          out  row consumed this cycle
//   acc            out  row unit accumulate strobe
//   div            out  row unit divide strobe
//   fifo_ext_rd    out  pop own sum towards the peer
//   peer_ready_out out  own sums complete (level, SYNC through DIV)
//   peer_ready_in  in   peer's peer_ready_out
//   out_valid      out  row unit output valid (div delayed one cycle)
//   row_idx        out  0-based index of the row being consumed
//   busy           out  controller not idle
//   done           out  one-cycle pulse at job end
//   err            out  one-cycle pulse: bad num_rows (or SYNC timeout)
//
// Build option: define SFP_TIMEOUT_EN to abort SYNC after 2^TO_W-1 cycles
// without peer_ready_in (err pulse, no done).

`default_nettype none

module sfp_ctrl #(
  parameter int MAX_ROWS = 16,
  parameter int RW       = 5,
  parameter int SETTLE   = 2,
  parameter int TO_W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] num_rows,
  input  logic          in_valid,
  output logic          in_rd,
  output logic          acc,
  output logic          div,
  output logic          fifo_ext_rd,
  output logic          peer_ready_out,
  input  logic          peer_ready_in,
  output logic          out_valid,
  output logic [RW-1:0] row_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACC    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SYNC   = 3'd3;
  localparam logic [2:0] ST_DIV    = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  // Settle counter only needs to hold 0..SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic          rst_meta_r;
  logic          rst_sync_r;

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [RW-1:0] rows_r;
  logic [RW-1:0] rows_s;
  logic [RW-1:0] row_r;
  logic [RW-1:0] row_s;
  logic [SW-1:0] scnt_r;
  logic [SW-1:0] scnt_s;
  logic          err_s;

  logic          busy_r;
  logic          ready_r;
  logic          done_r;
  logic          err_r;
  logic          out_valid_r;

  logic          in_acc_s;
  logic          in_div_s;
  logic          last_row_s;
  logic          size_ok_s;

`ifdef SFP_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] tcnt_r;
  logic [TO_W-1:0] tcnt_s;
`else
  logic [TO_W-1:0] unused_to_w;
  assign unused_to_w = '0;
`endif

  // Reset synchroniser: assertion is immediate, release waits two clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  assign in_acc_s   = (state_r == ST_ACC);
  assign in_div_s   = (state_r == ST_DIV);
  assign last_row_s = (row_r == (rows_r - RW'(1)));
  assign size_ok_s  = (num_rows != RW'(0)) && (num_rows <= RW'(MAX_ROWS));

  // Row strobes follow in_valid directly so a bubble costs no extra cycle.
  assign acc         = in_acc_s & in_valid;
  assign div         = in_div_s & in_valid;
  assign fifo_ext_rd = in_div_s & in_valid;
  assign in_rd       = (in_acc_s | in_div_s) & in_valid;

  assign row_idx        = row_r;
  assign busy           = busy_r;
  assign peer_ready_out = ready_r;
  assign done           = done_r;
  assign err            = err_r;
  assign out_valid      = out_valid_r;

  // Next-state and counter logic for the job sequence.
  always_comb begin
    state_s = state_r;
    rows_s  = rows_r;
    row_s   = row_r;
    scnt_s  = scnt_r;
    err_s   = 1'b0;
`ifdef SFP_TIMEOUT_EN
    tcnt_s  = tcnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (size_ok_s) begin
            state_s = ST_ACC;
            rows_s  = num_rows;
            row_s   = '0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          if (last_row_s) begin
            state_s = ST_SETTLE;
            row_s   = '0;
            scnt_s  = '0;
          end else begin
            row_s = row_r + RW'(1);
          end
        end else begin
          row_s = row_r;
        end
      end
      ST_SETTLE: begin
        if (scnt_r == SW'(SETTLE - 1)) begin
          state_s = ST_SYNC;
`ifdef SFP_TIMEOUT_EN
          tcnt_s  = '0;
`endif
        end else begin
          scnt_s = scnt_r + SW'(1);
        end
      end
      ST_SYNC: begin
        if (peer_ready_in) begin
          state_s = ST_DIV;
        end else begin
`ifdef SFP_TIMEOUT_EN
          // Abort on the cycle the counter would reach 2^TO_W-1.
          if (tcnt_r == TO_LAST) begin
            state_s = ST_IDLE;
            err_s   = 1'b1;
          end else begin
            tcnt_s = tcnt_r + TO_W'(1);
          end
`else
          state_s = ST_SYNC;
`endif
        end
      end
      ST_DIV: begin
        if (in_valid) begin
          if (last_row_s) begin
            state_s = ST_DRAIN;
            row_s   = '0;
          end else begin
            row_s = row_r + RW'(1);
          end
        end else begin
          row_s = row_r;
        end
      end
      ST_DRAIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        row_s   = '0;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r     <= ST_IDLE;
      rows_r      <= '0;
      row_r       <= '0;
      scnt_r      <= '0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rows_r      <= rows_s;
      row_r       <= row_s;
      scnt_r      <= scnt_s;
      busy_r      <= (state_s != ST_IDLE);
      ready_r     <= (state_s == ST_SYNC) || (state_s == ST_DIV);
      done_r      <= (state_s == ST_DRAIN);
      err_r       <= err_s;
      out_valid_r <= in_div_s & in_valid;
    end
  end

`ifdef SFP_TIMEOUT_EN
  // SYNC wait counter.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      tcnt_r <= '0;
    end else begin
      tcnt_r <= tcnt_s;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
- Sequencer for one core's softmax-style normalisation row unit (sfp_row).
- Drives the row unit's acc / div / fifo_ext_rd strobes across a job of N rows in two passes:
  - accumulate pass: per-row abs-sums pushed into the sum FIFOs;
  - divide pass: row values normalised by the two-core sum.
- Handshakes with the peer core's controller so neither core starts dividing before both sum FIFOs are filled.
- Gates upstream psum reads (in_valid/in_rd).

Parameters:
- MAX_ROWS, 16, row capacity per job; must not exceed sum FIFO depth.
- RW, 5, width of num_rows/row counters; must satisfy 2^RW > MAX_ROWS.
- SETTLE, 2, idle cycles after the last acc before peer_ready_out rises; covers sum_q register plus FIFO write.
- TO_W, 8, timeout counter width (used only with SFP_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all flops rising-edge.
- reset  in  1  asynchronous, active-low; asserted at 0.
- start  in  1  one-cycle job request; sampled only in IDLE.
- num_rows  in  RW  rows in job; captured on accepted start.
- in_valid  in  1  upstream row data (sfp_in of row unit) valid this cycle.
- in_rd  out  1  row consumed this cycle; upstream advances.
- acc  out  1  to row unit acc.
- div  out  1  to row unit div.
- fifo_ext_rd  out  1  to row unit fifo_ext_rd; pops own sum to peer.
- peer_ready_out  out  1  own sums complete; level.
- peer_ready_in  in  1  peer's peer_ready_out.
- out_valid  out  1  row unit sfp_out valid this cycle.
- row_idx  out  RW  index of row currently consumed, 0-based.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse: bad num_rows or timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; counters 0. Deassertion is synchronised internally. Reset mid-job aborts with no done.
- States: IDLE, ACC, SETTLE, SYNC, DIV, DRAIN.
- IDLE:
  - start && 1<=num_rows<=MAX_ROWS -> ACC; rows latched, row_idx=0.
  - start with num_rows==0 or >MAX_ROWS -> err pulse next cycle, stay IDLE.
- ACC:
  - in_rd=acc=in_valid (combinational). Each in_rd increments row_idx.
  - in_valid low = bubble; nothing is asserted.
  - After the in_rd with row_idx==rows-1 -> SETTLE; row_idx cleared.
- SETTLE: counts SETTLE cycles, then -> SYNC. acc=div=0.
- SYNC:
  - peer_ready_out=1 from SYNC entry through the end of DIV.
  - peer_ready_in==1 sampled -> DIV next cycle.
  - Both cores reaching SYNC in the same cycle both advance one cycle later.
- DIV:
  - in_rd=div=fifo_ext_rd=in_valid; acc=0. Each in_rd increments row_idx.
  - Each in_rd pops one entry of both the internal and external sum FIFO, so row k divides by sum_k + peer_sum_k.
  - Peer must also be in DIV for lockstep.
  - Bubbles are permitted only if both cores stall identically, which is the top-level's responsibility.
  - Last row -> DRAIN.
- DRAIN: one cycle. Then done=1 and -> IDLE; peer_ready_out drops the same cycle.
- out_valid = div delayed one cycle (registered). Exactly rows out_valid pulses per job; the last one coincides with the DRAIN cycle.
- acc and div are never high together. start is ignored while busy.
- row_idx holds its value during bubbles and stalls.

Optional Feature:
- Macro: SFP_TIMEOUT_EN.
- Defined:
  - SYNC counts cycles waiting for peer_ready_in.
  - On reaching 2^TO_W-1: err pulse, peer_ready_out=0, -> IDLE, no done.
  - Counter clears on SYNC entry.
- Undefined: SYNC waits indefinitely; err only signals bad num_rows.

Test Plan:
- Nominal: num_rows=4, in_valid=1 always, peer_ready_in tied to peer_ready_out.
  - 4 acc cycles, 2 settle cycles, 1 sync cycle, 4 div/fifo_ext_rd cycles.
  - out_valid pulses on the 4 cycles after each div; done 1 cycle after the last div; busy high from start+1 to done.
- Bubbles: num_rows=3, in_valid pattern 1,0,1,0,1 in ACC.
  - acc pulses exactly 3 times; row_idx goes 0,1,1,2,2; SETTLE entered after the 3rd acc.
- Peer late: peer_ready_in rises 10 cycles after own peer_ready_out.
  - div first asserted exactly 1 cycle after peer_ready_in rises; no acc/div during the wait.
- Bad size: start with num_rows=0, then with num_rows=17.
  - err pulses each time; busy stays 0; no in_rd.
- Reset mid-DIV: reset=0 after the 2nd div of 4.
  - All outputs 0 immediately (async); IDLE after release; a new start with num_rows=2 completes normally.
- SFP_TIMEOUT_EN, TO_W=4, peer_ready_in=0.
  - err pulse 15 cycles after SYNC entry; state IDLE; done never asserted.
